// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 64;
  localparam int BYTE_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory handshake bundle. The req_strb lane exists only when DMEM_STRB_EN is defined.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
`ifdef DMEM_STRB_EN
  logic [BYTE_N-1:0] req_strb;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_STRB_EN
    output req_strb,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_STRB_EN
    input  req_strb,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous byte-enabled write, read data captured into a register on access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cap,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [BYTE_N-1:0] i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the array has no reset; clearing every word would need a per-word reset path and contents are undefined after power-up anyway.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTE_N; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Stores and rejected addresses capture zero so the response reads back 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_rdata <= '0;
    else if (i_cap) r_rdata <= i_re ? r_mem[i_idx] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with WAIT_STATES wait cycles before each access.
// Optional byte strobes are enabled with the DMEM_STRB_EN macro.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [63:3]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_err;

  logic              w_accept, w_access;
  logic              w_acc_write, w_acc_err;
  logic [63:3]       w_acc_addr;
  logic [WORD_W-1:0] w_acc_wdata;
  logic [BYTE_N-1:0] w_acc_strb;
  logic [WORD_W-1:0] w_rdata;

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_access = (r_state == IDLE) ? (w_accept && (WAIT_STATES == 0))
                                      : ((r_state == WAIT) && (r_cnt == 4'd0));

  // With zero wait states the access happens on the accepting edge, so take the live bus values.
  assign w_acc_write = (r_state == IDLE) ? bus.req_write      : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr[63:3] : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata      : r_wdata;
  assign w_acc_err   = |w_acc_addr[63:3+AW];

`ifdef DMEM_STRB_EN
  logic [BYTE_N-1:0] r_strb;
  assign w_acc_strb = (r_state == IDLE) ? bus.req_strb : r_strb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_strb <= '0;
    else if (w_accept) r_strb <= bus.req_strb;
  end
`else
  assign w_acc_strb = '1;
`endif

  // NOTE: every clocked process uses <= so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr[63:3];
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept && (WAIT_STATES != 0)) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_err <= 1'b0;
    else if (w_access) r_err <= w_acc_err;
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_cap   (w_access),
    .i_we    (w_access && w_acc_write && !w_acc_err),
    .i_re    (w_access && !w_acc_write && !w_acc_err),
    .i_be    (w_acc_strb),
    .i_idx   (w_acc_addr[3 +: AW]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.rsp_rdata = w_rdata;
  assign bus.rsp_err   = r_err;

endmodule
